comb_always_rr_arbiter: RTL and testbench
=========================================

# comb_always_rr_arbiter

Four-requester round-robin arbiter and scheduler for the shared 4:1 data mux used by the combinational `case`/`if` datapath blocks. It grants one requester at a time and caps each tenure at a burst of accepted transfers. The selected input is steered to a single output with a valid/ready handshake. It serves as the sequential elaboration fixture alongside the combinational always-block cases, exercising `always_ff`, FSM `case`, `for`-loop priority search and `casez` one-hot decode.

## Interface
- `DATA_WIDTH`, default 4: width of each data input and of `out_data`.
- `MAX_BURST`, default 4: maximum number of accepted transfers per tenure; must be ≥1.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `req` input 4: per-requester request; bit i belongs to `in<i>`.
- `in0`..`in3` input DATA_WIDTH: per-requester data.
- `out_ready` input 1: downstream accepts `out_data` when high together with `out_valid`.
- `out_valid` output 1: owner data is presented.
- `out_data` output DATA_WIDTH: the owner's input; forced to 0 when `out_valid` is low.
- `grant` output 4: one-hot owner, 0 when idle.
- `grant_idx` output 2: binary owner index, holds its last value when idle.

## Operation
- FSM states:
  - IDLE: no owner; `grant` = 0.
  - GRANT: owner latched in `grant_idx`.
- IDLE:
  - If `req` ≠ 0, search begins at `ptr+1` mod 4 and the first set bit wins.
  - The search is a `for` loop over offsets 0..3 with a found flag.
  - At the edge: `grant_idx` ← winner, `grant` ← one-hot(winner), `burst_cnt` ← 0, state → GRANT.
  - If `req` = 0, stay in IDLE.
- GRANT:
  - `out_valid` = `req[grant_idx]`.
  - `out_data` = `case(grant_idx)` mux of `in0`..`in3`.
  - Transfer = `out_valid && out_ready`; each transfer increments `burst_cnt`.
- Tenure ends at the edge where:
  - `req[grant_idx]` = 0 (owner withdrew), or
  - a transfer occurs with `burst_cnt == MAX_BURST-1`.
- On tenure end: state → IDLE, `ptr` ← `grant_idx`, `grant` ← 0.
- Requests from other requesters during GRANT are ignored until the tenure ends; there is no preemption.
- `out_ready` low while `out_valid` is high stalls the transfer. Data tracks the `in*` inputs combinationally and is not held.
- `burst_cnt` width is `$clog2(MAX_BURST)+1`. It is cleared on each new grant and never wraps within a tenure.

## Timing
- Reset values:
  - state IDLE, `ptr` = 3 (so the first search starts at requester 0), `burst_cnt` = 0.
  - `grant` = 0, `grant_idx` = 0, `out_valid` = 0, `out_data` = 0.
- Reset asserted mid-tenure: immediate return to reset values; the in-flight transfer is dropped.
- Grant latency: `req` seen in IDLE in cycle N gives `grant`/`out_valid` in cycle N+1.
- Re-arbitration costs one IDLE bubble cycle between tenures, even with continuous requests.
- An owner dropping `req` and a transfer can never coincide, because `out_valid` requires `req`.
- `MAX_BURST` = 1: exactly one transfer per tenure.

## Configuration
- `RR_ARB_LOCK_EN` defined:
  - Adds input port `lock` (1 bit).
  - While `lock` is high, the burst limit is suppressed: `burst_cnt` saturates at `MAX_BURST-1` and the tenure ends only when the owner drops `req`.
  - When `lock` goes low, the next transfer ends the tenure.
- `RR_ARB_LOCK_EN` undefined: no `lock` port; the burst limit always applies.

## Test plan
- Reset, then `req`=4'b0000 for 5 cycles: `grant`=0, `out_valid`=0, `out_data`=0 throughout.
- `req`=4'b1111, `out_ready`=1, `in0..in3`=1,2,3,4, `MAX_BURST`=4:
  - Grants in order 0,1,2,3,0.
  - Each tenure shows 4 transfers, then 1 idle cycle.
  - `out_data` is 1, then 2, then 3, then 4 per tenure.
- `req`=4'b0100, `out_ready`=0 for 3 cycles then 1: `grant`=4'b0100 stable, `burst_cnt` frozen, 4 transfers counted after the stall.
- Owner 1 granted, `req[1]` dropped after 2 transfers while `req[3]`=1: one IDLE cycle, then `grant`=4'b1000.
- `rst` pulsed during a grant to requester 2: outputs return to 0 asynchronously; the next grant goes to requester 0 if `req`=4'b0101.
- With `RR_ARB_LOCK_EN`, `lock`=1, `req`=4'b0011:
  - Requester 0 keeps the grant for 10 transfers.
  - Drop `lock`: tenure ends after the next transfer, then `grant`=4'b0010.

Source files
------------

// File: rtl/comb_always_rr_arbiter.sv
// comb_always_rr_arbiter: four-requester round-robin arbiter that steers the
// owner's data onto a single valid/ready output, capping each tenure at
// MAX_BURST accepted transfers. One IDLE cycle separates consecutive tenures.
// Optional feature macro: RR_ARB_LOCK_EN adds a 'lock' input that suspends
// the burst cap while high (tenure then ends only when the owner drops req).
module comb_always_rr_arbiter #(
    parameter int DATA_WIDTH = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req,
    input  logic [DATA_WIDTH-1:0] in0,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    input  logic [DATA_WIDTH-1:0] in3,
    input  logic                  out_ready,
`ifdef RR_ARB_LOCK_EN
    input  logic                  lock,
`endif
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [3:0]            grant,
    output logic [1:0]            grant_idx
);

    localparam int            CW   = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nxt;
    logic [1:0]      ptr, ptr_nxt;
    logic [CW-1:0]   burst_cnt, cnt_nxt;
    logic [3:0]      grant_nxt;
    logic [1:0]      idx_nxt;

    logic [1:0]      cand;
    logic [1:0]      winner;
    logic            found;
    logic [3:0]      win_onehot;
    logic            owner_req;
    logic            xfer;
    logic            at_limit;
    logic            limit_hit;
    logic [DATA_WIDTH-1:0] mux_data;

    // Rotating-priority search: first set request starting just after ptr.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + 2'd1 + 2'(i);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // One-hot decode of the search result; zero when nothing is requesting.
    always_comb begin
        casez ({found, winner})
            3'b0??:  win_onehot = 4'b0000;
            3'b100:  win_onehot = 4'b0001;
            3'b101:  win_onehot = 4'b0010;
            3'b110:  win_onehot = 4'b0100;
            3'b111:  win_onehot = 4'b1000;
            default: win_onehot = 4'b0000;
        endcase
    end

    // Data steering from the current owner; output forced to 0 when not valid.
    always_comb begin
        case (grant_idx)
            2'd0:    mux_data = in0;
            2'd1:    mux_data = in1;
            2'd2:    mux_data = in2;
            2'd3:    mux_data = in3;
            default: mux_data = in0;
        endcase
    end

    assign owner_req = req[grant_idx];
    assign out_valid = (state == GRANT) && owner_req;
    assign out_data  = out_valid ? mux_data : '0;
    assign xfer      = out_valid && out_ready;
    // Counter sits at LAST once the final allowed transfer is pending
    // (and stays there while locked).
    assign at_limit  = (burst_cnt >= LAST);

`ifdef RR_ARB_LOCK_EN
    assign limit_hit = at_limit && !lock;
`else
    assign limit_hit = at_limit;
`endif

    // Next-state and registered-output logic for the IDLE/GRANT FSM.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = burst_cnt;
        grant_nxt = grant;
        idx_nxt   = grant_idx;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = GRANT;
                    idx_nxt   = winner;
                    grant_nxt = win_onehot;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (!owner_req || (xfer && limit_hit)) begin
                    state_nxt = IDLE;
                    ptr_nxt   = grant_idx;
                    grant_nxt = 4'b0000;
                end else if (xfer && !at_limit) begin
                    cnt_nxt = burst_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 4'b0000;
            end
        endcase
    end

    // State registers; reset drops any in-flight tenure immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 2'd3;
            burst_cnt <= '0;
            grant     <= 4'b0000;
            grant_idx <= 2'd0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            burst_cnt <= cnt_nxt;
            grant     <= grant_nxt;
            grant_idx <= idx_nxt;
        end
    end

endmodule

// File: tb/tb_comb_always_rr_arbiter.sv
// Bench for comb_always_rr_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a tenure-level model.
module tb_comb_always_rr_arbiter;

    localparam int DW = 4;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    req = '0;
    logic [DW-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic          out_ready = 1'b0;
`ifdef RR_ARB_LOCK_EN
    logic          lock = 1'b0;
`endif
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [3:0]    grant;
    logic [1:0]    grant_idx;

    int n_vec = 0;
    int n_bad = 0;

    comb_always_rr_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .out_ready(out_ready),
`ifdef RR_ARB_LOCK_EN
        .lock(lock),
`endif
        .out_valid(out_valid), .out_data(out_data),
        .grant(grant), .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic lock_now();
`ifdef RR_ARB_LOCK_EN
        return lock;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [DW-1:0] in_of(input int i);
        case (i)
            0: return in0;
            1: return in1;
            2: return in2;
            default: return in3;
        endcase
    endfunction

    // Tenure-level model: who owns the output, how many transfers it has
    // taken, and who owned last (round-robin start point).
    bit m_busy  = 0;
    int m_owner = 0;
    int m_last  = 3;
    int m_taken = 0;
    bit m_found;
    int m_c;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_owner = 0; m_last = 3; m_taken = 0;
        end else if (!m_busy) begin
            if (req != 4'b0) begin
                m_found = 0;
                for (int k = 1; k <= 4; k++) begin
                    m_c = (m_last + k) % 4;
                    if (!m_found && req[m_c]) begin
                        m_owner = m_c;
                        m_found = 1;
                    end
                end
                m_busy  = 1;
                m_taken = 0;
            end
        end else if (!req[m_owner]) begin
            m_busy = 0;
            m_last = m_owner;
        end else if (out_ready) begin
            m_taken++;
            if (m_taken >= MB && !lock_now()) begin
                m_busy = 0;
                m_last = m_owner;
            end
        end
    end

    // Compare DUT outputs with the model every cycle, mid-low-phase.
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic [3:0]    e_grant;
    always @(negedge clk) begin
        #1;
        e_valid = m_busy && req[m_owner];
        e_data  = e_valid ? in_of(m_owner) : '0;
        e_grant = m_busy ? (4'b0001 << m_owner) : 4'b0000;
        chk("model_grant", 32'(grant), 32'(e_grant));
        chk("model_grant_idx", 32'(grant_idx), 32'(m_owner));
        chk("model_valid", 32'(out_valid), 32'(e_valid));
        chk("model_data", 32'(out_data), 32'(e_data));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        @(negedge clk);
        #2;
    endtask

    int cnt;
    bit done;

    initial begin
        // Reset, then idle with no requests.
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            peek();
            chk("idle_grant", 32'(grant), 32'h0);
            chk("idle_valid", 32'(out_valid), 32'h0);
            chk("idle_data", 32'(out_data), 32'h0);
            tick();
        end

        // All requesting, ready high: 0,1,2,3,0 with 4 transfers each and a bubble.
        in0 = 4'd1; in1 = 4'd2; in2 = 4'd3; in3 = 4'd4;
        req = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i <= 21; i++) begin
            peek();
            chk("rr_grant", 32'(grant), (i % 5 == 0) ? 32'h0 : 32'(4'b0001 << ((i / 5) % 4)));
            chk("rr_data", 32'(out_data), (i % 5 == 0) ? 32'h0 : 32'((i / 5) % 4 + 1));
            tick();
        end
        req = 4'b0000;
        tick();

        // Stall: requester 2 alone, ready low for 3 cycles then high.
        req = 4'b0100; out_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            peek();
            chk("stall_grant", 32'(grant), 32'h4);
            chk("stall_valid", 32'(out_valid), 32'h1);
            tick();
        end
        out_ready = 1'b1;
        cnt = 0; done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            peek();
            if (grant == 4'b0100 && out_valid) cnt++;
            if (grant == 4'b0000) begin
                done = 1;
                req  = 4'b0000;
            end
            tick();
        end
        chk("stall_done", 32'(done), 32'h1);
        chk("stall_xfers", 32'(cnt), 32'd4);

        // Owner 1 withdraws after 2 transfers while requester 3 waits.
        req = 4'b0010;
        tick();
        req = 4'b1010;
        peek();
        chk("wd_grant", 32'(grant), 32'h2);
        chk("wd_data", 32'(out_data), 32'h2);
        tick(); tick();
        req = 4'b1000;
        peek();
        chk("wd_drop_grant", 32'(grant), 32'h2);
        chk("wd_drop_valid", 32'(out_valid), 32'h0);
        tick();
        peek();
        chk("wd_bubble", 32'(grant), 32'h0);
        tick();
        peek();
        chk("wd_next", 32'(grant), 32'h8);

        // Asynchronous reset in the middle of a grant to requester 2.
        req = 4'b0000;
        tick();
        req = 4'b0100;
        tick();
        peek();
        chk("pre_rst_grant", 32'(grant), 32'h4);
        rst = 1'b1;
        #1;
        chk("arst_grant", 32'(grant), 32'h0);
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_data", 32'(out_data), 32'h0);
        chk("arst_idx", 32'(grant_idx), 32'h0);
        req = 4'b0101;
        tick();
        rst = 1'b0;
        peek();
        chk("post_rst_idle", 32'(grant), 32'h0);
        tick();
        peek();
        chk("post_rst_grant", 32'(grant), 32'h1);

`ifdef RR_ARB_LOCK_EN
        // Lock holds requester 0 past the burst cap.
        rst = 1'b1; req = 4'b0000;
        tick(); tick();
        rst = 1'b0;
        lock = 1'b1; req = 4'b0011; out_ready = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            peek();
            chk("lock_grant", 32'(grant), 32'h1);
            chk("lock_valid", 32'(out_valid), 32'h1);
            tick();
        end
        lock = 1'b0;
        peek();
        chk("unlock_grant", 32'(grant), 32'h1);
        tick();
        peek();
        chk("unlock_bubble", 32'(grant), 32'h0);
        tick();
        peek();
        chk("unlock_next", 32'(grant), 32'h2);
`endif

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 2000; i++) begin
            tick();
            rst       = ($urandom_range(0, 149) == 0);
            req       = 4'($urandom);
            if ($urandom_range(0, 3) == 0) req = 4'b0000;
            out_ready = ($urandom_range(0, 3) != 0);
            in0 = DW'($urandom); in1 = DW'($urandom);
            in2 = DW'($urandom); in3 = DW'($urandom);
`ifdef RR_ARB_LOCK_EN
            if ($urandom_range(0, 7) == 0) lock = ~lock;
`endif
        end
        rst = 1'b0;
        tick();
        peek();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
